// File: rtl/lifo_pop_streamer.sv
// lifo_pop_streamer: read-side master for the 8-deep LIFO stack.
// Accepts burst-pop commands, strobes the stack read port, captures popped
// bytes into a 2-entry output FIFO and presents them as a valid/ready stream
// with a last marker. Turns the stack's fixed one-cycle read latency and lack
// of back-pressure into a flow-controlled stream.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       burst command handshake
//   cmd_len                   entries to pop, 0 = drain until stack empty
//   stk_rd                    pop strobe to stack rn (combinational)
//   stk_wr                    copy of stack wn (a write wins over a read)
//   stk_empty, stk_data       stack empty flag and read data
//   m_valid/m_ready/m_data/m_last   output stream
//   busy                      command accepted, last beat not yet consumed
//   underrun                  sticky: nonzero burst ended early on empty stack
//   pop_count                 issued-pop statistics counter
//
// Optional build macro LIFO_POP_STATS_EN: when defined, pop_count is a
// saturating 16-bit count of issued pops; otherwise it is tied to zero.

module lifo_pop_streamer #(
    parameter int unsigned W    = 8,
    parameter int unsigned LENW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [LENW-1:0] cmd_len,
    output logic            stk_rd,
    input  logic            stk_wr,
    input  logic            stk_empty,
    input  logic [W-1:0]    stk_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    m_data,
    output logic            m_last,
    output logic            busy,
    output logic            underrun,
    output logic [15:0]     pop_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POP   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          state_q;
    logic [LENW-1:0] remaining_q;
    logic            drain_q;
    logic            inflight_q;       // a pop was issued last cycle; data on stk_data now
    logic            term_inflight_q;  // that pop was the terminating one
    logic            underrun_q;
    logic            busy_q;

    logic [W-1:0]    fifo_data_q [2];
    logic [1:0]      fifo_last_q;
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic [1:0]      count_d;

    logic            fifo_wr;
    logic            fifo_rd;
    logic            cap_last;
    logic            term_pop;
    logic            credit_ok;
    logic            flush_done;
    logic [2:0]      credit_use;

    // Output FIFO head and handshake
    assign m_valid  = (count_q != 2'd0);
    assign fifo_rd  = m_valid && m_ready;
    assign fifo_wr  = inflight_q;
    assign m_data   = m_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign m_last   = m_valid && fifo_last_q[rd_ptr_q];
    assign count_d  = count_q + 2'(fifo_wr) - 2'(fifo_rd);

    // stk_empty in the capture cycle already reflects the pop being captured
    assign cap_last = term_inflight_q || stk_empty;

    // Credit counts the beat leaving this cycle so a full-rate stream never stalls
    assign credit_use = 3'(count_q) - 3'(fifo_rd) + 3'(inflight_q);
    assign credit_ok  = (credit_use < 3'd2);

    assign term_pop = !drain_q && (remaining_q == LENW'(1));

    // Pop strobe must react to stk_wr in the same cycle, so it is combinational
    assign stk_rd = (state_q == S_POP) && !stk_empty && !stk_wr && credit_ok
                    && !term_inflight_q;

    // Leave FLUSH in the same cycle the final beat is taken
    assign flush_done = !inflight_q &&
                        ((count_q == 2'd0) || ((count_q == 2'd1) && fifo_rd));

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign busy      = busy_q;
    assign underrun  = underrun_q;

    // Control FSM, pop accounting and output FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            remaining_q     <= '0;
            drain_q         <= 1'b0;
            inflight_q      <= 1'b0;
            term_inflight_q <= 1'b0;
            underrun_q      <= 1'b0;
            busy_q          <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= 2'b00;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            if (fifo_wr) begin
                fifo_data_q[wr_ptr_q] <= stk_data;
                fifo_last_q[wr_ptr_q] <= cap_last;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (fifo_rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q         <= count_d;
            inflight_q      <= stk_rd;
            term_inflight_q <= stk_rd && term_pop;

            if (stk_rd && !drain_q) begin
                remaining_q <= remaining_q - LENW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        remaining_q <= cmd_len;
                        drain_q     <= (cmd_len == '0);
                        underrun_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_POP;
                    end
                end
                S_POP: begin
                    if (!inflight_q && stk_empty) begin
                        // Nothing to pop at all: finish without emitting beats
                        underrun_q <= !drain_q;
                        if (count_q == 2'd0) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_FLUSH;
                        end
                    end else if (inflight_q && stk_empty) begin
                        // Captured beat emptied the stack: it carries last
                        if (!drain_q && !term_inflight_q) begin
                            underrun_q <= 1'b1;
                        end
                        state_q <= S_FLUSH;
                    end else if (stk_rd && term_pop) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (flush_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LIFO_POP_STATS_EN
    logic [15:0] pop_count_q;

    // Saturating issued-pop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_count_q <= 16'd0;
        end else if (stk_rd && (pop_count_q != 16'hFFFF)) begin
            pop_count_q <= pop_count_q + 16'd1;
        end
    end

    assign pop_count = pop_count_q;
`else
    assign pop_count = 16'd0;
`endif

endmodule

// File: tb/tb_lifo_pop_streamer.sv
// Testbench for lifo_pop_streamer: behavioural 8-deep stack environment,
// directed scenarios and randomized bursts checked against an expected-beat
// model derived from the stack contents snapshot.

module tb_lifo_pop_streamer;

    localparam int unsigned W    = 8;
    localparam int unsigned LENW = 4;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [LENW-1:0] cmd_len   = '0;
    logic            stk_rd;
    logic            stk_wr    = 1'b0;
    logic            stk_empty;
    logic [W-1:0]    stk_data;
    logic            m_valid;
    logic            m_ready   = 1'b0;
    logic [W-1:0]    m_data;
    logic            m_last;
    logic            busy;
    logic            underrun;
    logic [15:0]     pop_count;

    always #5 clk = ~clk;

    lifo_pop_streamer #(.W(W), .LENW(LENW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .stk_rd    (stk_rd),
        .stk_wr    (stk_wr),
        .stk_empty (stk_empty),
        .stk_data  (stk_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .underrun  (underrun),
        .pop_count (pop_count)
    );

    // Stack environment: write wins over read, data one cycle after the pop,
    // not affected by the streamer's reset.
    logic [7:0] stk_mem [0:7];
    logic [3:0] sp_q    = 4'd0;
    logic [7:0] stk_out = 8'd0;
    logic [7:0] wdata   = 8'd0;

    always @(posedge clk) begin
        if (stk_wr) begin
            if (sp_q < 4'd8) begin
                stk_mem[sp_q[2:0]] <= wdata;
                sp_q               <= sp_q + 4'd1;
            end
        end else if (stk_rd && (sp_q != 4'd0)) begin
            stk_out <= stk_mem[3'(sp_q - 4'd1)];
            sp_q    <= sp_q - 4'd1;
        end
    end

    assign stk_empty = (sp_q == 4'd0);
    assign stk_data  = stk_out;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the most recent burst
    logic [7:0]  got_data [$];
    logic        got_last [$];
    logic [7:0]  exp_d [$];
    logic        exp_l [$];
    int          first_rd;
    int          first_vld;
    int          done_cyc;
    int          pops;
    int          max_out;
    int          clash;
    logic        und_c1;
    logic        busy_c1;
    logic        und_end;
    logic [15:0] pc_start;
    logic [15:0] pc_end;

    task automatic push_byte(input logic [7:0] v);
        stk_wr = 1'b1;
        wdata  = v;
        @(posedge clk);
        #1;
        stk_wr = 1'b0;
    endtask

    // Issue one command and follow it cycle by cycle until cmd_ready returns.
    // rmode: 0 = m_ready held high, 1 = random m_ready, 2 = low 5 cycles after first beat
    task automatic run_burst(input int len, input int rmode, input int wr_cyc,
                             input logic [7:0] wr_val);
        int hold;
        int outst;
        got_data.delete();
        got_last.delete();
        first_rd  = -1;
        first_vld = -1;
        done_cyc  = -1;
        pops      = 0;
        max_out   = 0;
        clash     = 0;
        hold      = 0;
        und_c1    = 1'bx;
        busy_c1   = 1'bx;
        und_end   = 1'bx;
        pc_start  = pop_count;
        pc_end    = 16'hxxxx;
        cmd_valid = 1'b1;
        cmd_len   = LENW'(len);
        m_ready   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (rmode == 0) begin
                m_ready = 1'b1;
            end else if (rmode == 1) begin
                m_ready = 1'($urandom_range(0, 1));
            end else if (hold > 0) begin
                m_ready = 1'b0;
                hold--;
            end else begin
                m_ready = 1'b1;
            end
            stk_wr = (cyc == wr_cyc);
            wdata  = wr_val;
            @(negedge clk);
            if (cyc == 1) begin
                und_c1  = underrun;
                busy_c1 = busy;
            end
            if (stk_rd) begin
                pops++;
                if (first_rd < 0) first_rd = cyc;
                if (stk_wr) clash++;
            end
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                if (first_vld < 0) first_vld = cyc;
                if (rmode == 2 && got_data.size() == 1) hold = 5;
            end
            outst = pops - got_data.size();
            if (outst > max_out) max_out = outst;
            if (cmd_ready) begin
                done_cyc = cyc;
                und_end  = underrun;
                pc_end   = pop_count;
            end
            @(posedge clk);
            #1;
            if (done_cyc >= 0) break;
        end
        stk_wr  = 1'b0;
        m_ready = 1'b0;
        n_cmp++;
        if (done_cyc < 0) begin
            n_err++;
            $display("FAIL burst_timeout: cmd_ready not back within 200 cycles (len %0d)", len);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, stk_rd, m_valid, m_last, busy, underrun} !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_flags: rdy/rd/vld/last/busy/und=%b required 000000",
                     {cmd_ready, stk_rd, m_valid, m_last, busy, underrun});
        end
        n_cmp++;
        if (m_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_m_data: got %h required 00", m_data);
        end
        n_cmp++;
        if (pop_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_pop_count: got %0d required 0", pop_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_cmd_ready_after: got %b required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_len2();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        run_burst(2, 0, -1, 8'h00);
        exp_d = '{8'h33, 8'h22};
        exp_l = '{1'b0, 1'b1};
        n_cmp++;
        if (got_data.size() !== exp_d.size()) begin
            n_err++;
            $display("FAIL len2_count: got %0d beats required %0d", got_data.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            n_cmp++;
            if (i >= got_data.size()) begin
                n_err++;
                $display("FAIL len2_beat%0d: missing, required %h", i, exp_d[i]);
            end else if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL len2_beat%0d: got %h/last %b required %h/last %b",
                         i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++;
        if (und_end !== 1'b0 || busy_c1 !== 1'b1) begin
            n_err++;
            $display("FAIL len2_flags: underrun=%b busy@1=%b required 0/1", und_end, busy_c1);
        end
        n_cmp++;
        if (first_rd !== 1 || first_vld !== 3) begin
            n_err++;
            $display("FAIL len2_latency: first rd cyc %0d, first valid cyc %0d required 1/3",
                     first_rd, first_vld);
        end
        n_cmp++;
        if (sp_q !== 4'd1 || stk_mem[0] !== 8'h11) begin
            n_err++;
            $display("FAIL len2_stack_left: depth %0d bottom %h required 1/11", sp_q, stk_mem[0]);
        end
    endtask

    task automatic test_drain();
        push_byte(8'h22);
        push_byte(8'h33);
        run_burst(0, 0, -1, 8'h00);
        exp_d = '{8'h33, 8'h22, 8'h11};
        exp_l = '{1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (got_data.size() !== exp_d.size()) begin
            n_err++;
            $display("FAIL drain_count: got %0d beats required %0d", got_data.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            n_cmp++;
            if (i >= got_data.size()) begin
                n_err++;
                $display("FAIL drain_beat%0d: missing, required %h", i, exp_d[i]);
            end else if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL drain_beat%0d: got %h/last %b required %h/last %b",
                         i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++;
        if (und_end !== 1'b0 || sp_q !== 4'd0) begin
            n_err++;
            $display("FAIL drain_end: underrun=%b depth=%0d required 0/0", und_end, sp_q);
        end
    endtask

    task automatic test_underrun();
        push_byte(8'h44);
        push_byte(8'h55);
        run_burst(5, 0, -1, 8'h00);
        exp_d = '{8'h55, 8'h44};
        exp_l = '{1'b0, 1'b1};
        n_cmp++;
        if (got_data.size() !== exp_d.size()) begin
            n_err++;
            $display("FAIL underrun_count: got %0d beats required %0d", got_data.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            n_cmp++;
            if (i >= got_data.size()) begin
                n_err++;
                $display("FAIL underrun_beat%0d: missing, required %h", i, exp_d[i]);
            end else if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL underrun_beat%0d: got %h/last %b required %h/last %b",
                         i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++;
        if (und_end !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_flag: got %b required 1", und_end);
        end
    endtask

    task automatic test_empty();
        // underrun still set from the previous burst; accept must clear it
        run_burst(3, 0, -1, 8'h00);
        n_cmp++;
        if (und_c1 !== 1'b0) begin
            n_err++;
            $display("FAIL empty_clear_on_accept: underrun=%b required 0", und_c1);
        end
        n_cmp++;
        if (got_data.size() !== 0 || pops !== 0) begin
            n_err++;
            $display("FAIL empty_no_beats: beats %0d pops %0d required 0/0", got_data.size(), pops);
        end
        n_cmp++;
        if (und_end !== 1'b1) begin
            n_err++;
            $display("FAIL empty_underrun: got %b required 1", und_end);
        end
        n_cmp++;
        if (done_cyc < 1 || done_cyc > 2) begin
            n_err++;
            $display("FAIL empty_ready_return: cmd_ready back at cycle %0d required <=2", done_cyc);
        end
        run_burst(0, 0, -1, 8'h00);
        n_cmp++;
        if (und_end !== 1'b0 || got_data.size() !== 0) begin
            n_err++;
            $display("FAIL empty_drain: underrun=%b beats=%0d required 0/0", und_end, got_data.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = 8'($urandom);
            push_byte(v[i]);
        end
        run_burst(4, 2, -1, 8'h00);
        exp_d = '{v[3], v[2], v[1], v[0]};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (got_data.size() !== exp_d.size()) begin
            n_err++;
            $display("FAIL bp_count: got %0d beats required %0d", got_data.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            n_cmp++;
            if (i >= got_data.size()) begin
                n_err++;
                $display("FAIL bp_beat%0d: missing, required %h", i, exp_d[i]);
            end else if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL bp_beat%0d: got %h/last %b required %h/last %b",
                         i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++;
        if (max_out > 2) begin
            n_err++;
            $display("FAIL bp_outstanding: max %0d pops outstanding required <=2", max_out);
        end
    endtask

    task automatic test_stk_wr();
        logic [7:0] v [5];
        for (int i = 0; i < 5; i++) begin
            v[i] = 8'($urandom);
            push_byte(v[i]);
        end
        run_burst(4, 0, 2, 8'hA5);
        exp_d = '{v[4], 8'hA5, v[3], v[2]};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (clash !== 0) begin
            n_err++;
            $display("FAIL wr_rd_clash: stk_rd high with stk_wr in %0d cycles required 0", clash);
        end
        n_cmp++;
        if (got_data.size() !== exp_d.size()) begin
            n_err++;
            $display("FAIL wr_count: got %0d beats required %0d", got_data.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            n_cmp++;
            if (i >= got_data.size()) begin
                n_err++;
                $display("FAIL wr_beat%0d: missing, required %h", i, exp_d[i]);
            end else if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL wr_beat%0d: got %h/last %b required %h/last %b",
                         i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++;
        if (sp_q !== 4'd2) begin
            n_err++;
            $display("FAIL wr_stack_left: depth %0d required 2", sp_q);
        end
`ifdef LIFO_POP_STATS_EN
        n_cmp++;
        if (16'(pc_end - pc_start) !== 16'd4) begin
            n_err++;
            $display("FAIL wr_pop_count: delta %0d required 4", 16'(pc_end - pc_start));
        end
`else
        n_cmp++;
        if (pc_end !== 16'd0) begin
            n_err++;
            $display("FAIL wr_pop_count_off: got %0d required 0", pc_end);
        end
`endif
        run_burst(0, 0, -1, 8'h00);
    endtask

    task automatic test_reset_mid();
        logic [7:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = 8'($urandom);
            push_byte(v[i]);
        end
        cmd_valid = 1'b1;
        cmd_len   = LENW'(4);
        m_ready   = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, m_valid, busy, underrun} !== 4'b0000) begin
            n_err++;
            $display("FAIL midrst_flags: rdy/vld/busy/und=%b required 0000",
                     {cmd_ready, m_valid, busy, underrun});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // With m_ready low the credit limit allows exactly two pops
        n_cmp++;
        if (sp_q !== 4'd2) begin
            n_err++;
            $display("FAIL midrst_stack_left: depth %0d required 2", sp_q);
        end
        run_burst(0, 0, -1, 8'h00);
        exp_d = '{v[1], v[0]};
        exp_l = '{1'b0, 1'b1};
        n_cmp++;
        if (got_data.size() !== exp_d.size()) begin
            n_err++;
            $display("FAIL midrst_count: got %0d beats required %0d", got_data.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            n_cmp++;
            if (i >= got_data.size()) begin
                n_err++;
                $display("FAIL midrst_beat%0d: missing, required %h", i, exp_d[i]);
            end else if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL midrst_beat%0d: got %h/last %b required %h/last %b",
                         i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    // Random fills, lengths and back-pressure against the snapshot model
    task automatic test_random();
        logic [7:0] snap [8];
        int depth;
        int len;
        int n;
        logic exp_und;
        for (int it = 0; it < 24; it++) begin
            depth = int'(sp_q);
            for (int k = $urandom_range(0, 8 - depth); k > 0; k--) begin
                push_byte(8'($urandom));
            end
            depth = int'(sp_q);
            for (int i = 0; i < depth; i++) snap[i] = stk_mem[3'(i)];
            len     = int'($urandom_range(0, 15));
            n       = (len == 0) ? depth : ((len < depth) ? len : depth);
            exp_und = (len != 0) && (len > depth);
            run_burst(len, 1, -1, 8'h00);
            n_cmp++;
            if (got_data.size() !== n) begin
                n_err++;
                $display("FAIL rand%0d_count: got %0d beats required %0d (len %0d depth %0d)",
                         it, got_data.size(), n, len, depth);
            end
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (i >= got_data.size()) begin
                    n_err++;
                    $display("FAIL rand%0d_beat%0d: missing, required %h", it, i, snap[depth-1-i]);
                end else if (got_data[i] !== snap[depth-1-i] || got_last[i] !== (i == n - 1)) begin
                    n_err++;
                    $display("FAIL rand%0d_beat%0d: got %h/last %b required %h/last %b",
                             it, i, got_data[i], got_last[i], snap[depth-1-i], (i == n - 1));
                end
            end
            n_cmp++;
            if (und_end !== exp_und) begin
                n_err++;
                $display("FAIL rand%0d_underrun: got %b required %b", it, und_end, exp_und);
            end
            n_cmp++;
            if (int'(sp_q) !== depth - n) begin
                n_err++;
                $display("FAIL rand%0d_stack_left: depth %0d required %0d", it, sp_q, depth - n);
            end
`ifdef LIFO_POP_STATS_EN
            n_cmp++;
            if (16'(pc_end - pc_start) !== 16'(n)) begin
                n_err++;
                $display("FAIL rand%0d_pop_count: delta %0d required %0d",
                         it, 16'(pc_end - pc_start), n);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_len2();
        test_drain();
        test_underrun();
        test_empty();
        test_backpressure();
        test_stk_wr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
